// File: rtl/riscv_ex_ctrl.sv
// Execute-stage sequencer: drives the combinational ALU, holds a single-entry EX/WB
// result register, and turns taken branches/jumps into a redirect plus flush window.
module riscv_ex_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter bit FWD_EN       = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  output logic             o_id_ready,
  input  logic [6:0]       i_opcode,
  input  logic [6:0]       i_funct7,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rs1_idx,
  input  logic [4:0]       i_rs2_idx,
  input  logic [4:0]       i_rd_idx,
  input  logic [31:0]      i_rs1_val,
  input  logic [31:0]      i_rs2_val,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_pc,
  output logic [6:0]       o_alu_opcode,
  output logic [6:0]       o_alu_funct7,
  output logic [2:0]       o_alu_funct3,
  output logic [31:0]      o_alu_num1,
  output logic [31:0]      o_alu_num2,
  output logic [31:0]      o_alu_imm,
  output logic [31:0]      o_alu_pc,
  input  logic             i_alu_if_branch,
  input  logic [31:0]      i_alu_num,
  input  logic [31:0]      i_alu_pc,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [31:0]      o_wb_data,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [CNT_W-1:0] o_redirect_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_we_q, wb_we_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               redir_valid_q, redir_valid_d;
  logic [31:0]        redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;

  logic id_ready;
  logic accept;
  logic wb_hs;
  logic fwd_ok;

  // In FLUSH every offered instruction is swallowed, so ready is unconditional there.
  assign id_ready = (state_q == FLUSH) || !wb_valid_q || i_wb_ready;
  assign accept   = (state_q == RUN) && i_id_valid && id_ready;
  assign wb_hs    = wb_valid_q && i_wb_ready;
  assign fwd_ok   = FWD_EN && wb_valid_q && wb_we_q;

  always_comb begin
    o_alu_opcode = i_opcode;
    o_alu_funct7 = i_funct7;
    o_alu_funct3 = i_funct3;
    o_alu_imm    = i_imm;
    o_alu_pc     = i_pc;
    o_alu_num1   = i_rs1_val;
    o_alu_num2   = i_rs2_val;
    if (fwd_ok && (wb_rd_q == i_rs1_idx) && (i_rs1_idx != 5'd0)) o_alu_num1 = wb_data_q;
    if (fwd_ok && (wb_rd_q == i_rs2_idx) && (i_rs2_idx != 5'd0)) o_alu_num2 = wb_data_q;
  end

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    wb_valid_d     = wb_valid_q;
    wb_we_d        = wb_we_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    redir_valid_d  = 1'b0;
    redir_pc_d     = redir_pc_q;
    retire_cnt_d   = retire_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    if (state_q == FLUSH) begin
      if (fcnt_q == 4'd0) state_d = RUN;
      else                fcnt_d  = fcnt_q - 4'd1;
    end

    // An accept reloads the register even when the old result drains in the same cycle.
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = i_rd_idx;
      wb_data_d  = i_alu_num;
      wb_we_d    = !((i_opcode == OP_BRANCH) || (i_opcode == OP_STORE) || (i_rd_idx == 5'd0));
      if (i_alu_if_branch) begin
        state_d        = FLUSH;
        fcnt_d         = FCNT_LOAD;
        redir_valid_d  = 1'b1;
        redir_pc_d     = {i_alu_pc[31:1], 1'b0};
        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end
    end else if (wb_hs) begin
      wb_valid_d = 1'b0;
    end

    if (wb_hs) retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= RUN;
      fcnt_q         <= 4'd0;
      wb_valid_q     <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'd0;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= 32'd0;
      retire_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_we_q        <= wb_we_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      redir_valid_q  <= redir_valid_d;
      redir_pc_q     <= redir_pc_d;
      retire_cnt_q   <= retire_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign o_id_ready       = id_ready;
  assign o_wb_valid       = wb_valid_q;
  assign o_wb_we          = wb_we_q;
  assign o_wb_rd          = wb_rd_q;
  assign o_wb_data        = wb_data_q;
  assign o_redirect_valid = redir_valid_q;
  assign o_redirect_pc    = redir_pc_q;
  assign o_flush          = (state_q == FLUSH);
  assign o_retire_cnt     = retire_cnt_q;
  assign o_redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_riscv_ex_ctrl.sv
// Scoreboard bench for riscv_ex_ctrl; a second instance without forwarding
// shares the stimulus for the no-forwarding operand case.
module tb_riscv_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic        alu_br;
  logic [31:0] alu_num, alu_pc;
  logic        wb_ready;

  logic        id_ready, wb_valid, wb_we, redir_valid, flush;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3;
  logic [31:0] a_num1, a_num2, a_imm, a_pc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, redir_pc;
  logic [31:0] retire_cnt, redirect_cnt;

  logic        n_id_ready, n_wb_valid, n_wb_we, n_redir_valid, n_flush;
  logic [6:0]  n_opcode, n_funct7;
  logic [2:0]  n_funct3;
  logic [31:0] n_num1, n_num2, n_imm, n_pc;
  logic [4:0]  n_wb_rd;
  logic [31:0] n_wb_data, n_redir_pc;
  logic [31:0] n_retire_cnt, n_redirect_cnt;

  int vec = 0;
  int errs = 0;
  logic [37:0] sb_q[$];

  always #5 clk = ~clk;

  riscv_ex_ctrl #(.FLUSH_CYCLES(2), .FWD_EN(1'b1), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .o_id_ready(id_ready),
    .i_opcode(opcode), .i_funct7(funct7), .i_funct3(funct3),
    .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx), .i_rd_idx(rd_idx),
    .i_rs1_val(rs1_val), .i_rs2_val(rs2_val), .i_imm(imm), .i_pc(pc),
    .o_alu_opcode(a_opcode), .o_alu_funct7(a_funct7), .o_alu_funct3(a_funct3),
    .o_alu_num1(a_num1), .o_alu_num2(a_num2), .o_alu_imm(a_imm), .o_alu_pc(a_pc),
    .i_alu_if_branch(alu_br), .i_alu_num(alu_num), .i_alu_pc(alu_pc),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_we(wb_we), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_redirect_valid(redir_valid), .o_redirect_pc(redir_pc),
    .o_flush(flush), .o_retire_cnt(retire_cnt), .o_redirect_cnt(redirect_cnt)
  );

  riscv_ex_ctrl #(.FLUSH_CYCLES(2), .FWD_EN(1'b0), .CNT_W(32)) dut_nf (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .o_id_ready(n_id_ready),
    .i_opcode(opcode), .i_funct7(funct7), .i_funct3(funct3),
    .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx), .i_rd_idx(rd_idx),
    .i_rs1_val(rs1_val), .i_rs2_val(rs2_val), .i_imm(imm), .i_pc(pc),
    .o_alu_opcode(n_opcode), .o_alu_funct7(n_funct7), .o_alu_funct3(n_funct3),
    .o_alu_num1(n_num1), .o_alu_num2(n_num2), .o_alu_imm(n_imm), .o_alu_pc(n_pc),
    .i_alu_if_branch(alu_br), .i_alu_num(alu_num), .i_alu_pc(alu_pc),
    .o_wb_valid(n_wb_valid), .i_wb_ready(wb_ready), .o_wb_we(n_wb_we), .o_wb_rd(n_wb_rd),
    .o_wb_data(n_wb_data), .o_redirect_valid(n_redir_valid), .o_redirect_pc(n_redir_pc),
    .o_flush(n_flush), .o_retire_cnt(n_retire_cnt), .o_redirect_cnt(n_redirect_cnt)
  );

  // Writeback monitor: every handshake pops one expected {we, rd, data}.
  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      vec++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_wb: got we=%0b rd=%0d data=%h, expected none", wb_we, wb_rd, wb_data);
      end else begin
        e = sb_q.pop_front();
        if ({wb_we, wb_rd, wb_data} !== e) begin
          errs++;
          $display("FAIL sb_wb: got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                   wb_we, wb_rd, wb_data, e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] p, input logic [31:0] anum,
                           input logic br, input logic [31:0] apc);
    opcode = op; funct7 = 7'h00; funct3 = 3'h0;
    rs1_idx = r1; rs2_idx = r2; rd_idx = rd;
    rs1_val = v1; rs2_val = v2; imm = anum; pc = p;
    alu_num = anum; alu_br = br; alu_pc = apc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b0; wb_ready = 1'b1;
    set_instr(7'h13, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    vec++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL rst_wb_valid: got %0b expected 0", wb_valid); end
    vec++; if ({wb_we, wb_rd, wb_data} !== 38'd0) begin errs++; $display("FAIL rst_wb_fields: got %h expected 0", {wb_we, wb_rd, wb_data}); end
    vec++; if ({redir_valid, redir_pc, flush} !== 34'd0) begin errs++; $display("FAIL rst_redirect: got %h expected 0", {redir_valid, redir_pc, flush}); end
    vec++; if ({retire_cnt, redirect_cnt} !== 64'd0) begin errs++; $display("FAIL rst_counters: got %h expected 0", {retire_cnt, redirect_cnt}); end
    vec++; if (id_ready !== 1'b1) begin errs++; $display("FAIL rst_id_ready: got %0b expected 1", id_ready); end
  endtask

  task automatic test_addi();
    set_instr(7'b0010011, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h0, 32'd5, 1'b0, 32'd0);
    wb_ready = 1'b1; id_valid = 1'b1;
    #1;
    vec++; if (a_imm !== 32'd5 || a_opcode !== 7'b0010011) begin errs++; $display("FAIL addi_alu_drive: got op=%h imm=%h expected op=13 imm=5", a_opcode, a_imm); end
    sb_q.push_back({1'b1, 5'd1, 32'd5});
    cyc();
    id_valid = 1'b0;
    vec++; if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd1, 32'd5}) begin
      errs++; $display("FAIL addi_wb: got v=%0b we=%0b rd=%0d data=%h expected 1 1 1 5", wb_valid, wb_we, wb_rd, wb_data);
    end
    cyc();
    vec++; if (retire_cnt !== 32'd1) begin errs++; $display("FAIL addi_retire_cnt: got %0d expected 1", retire_cnt); end
    vec++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL addi_wb_drained: got %0b expected 0", wb_valid); end
  endtask

  task automatic test_forward_stall();
    wb_ready = 1'b0;
    set_instr(7'b0010011, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h0, 32'd5, 1'b0, 32'd0);
    id_valid = 1'b1;
    sb_q.push_back({1'b1, 5'd1, 32'd5});
    cyc();
    set_instr(7'b0110011, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'h4, 32'd10, 1'b0, 32'd0);
    #1;
    vec++; if (a_num1 !== 32'd5 || a_num2 !== 32'd5) begin errs++; $display("FAIL fwd_on: got num1=%h num2=%h expected 5 5", a_num1, a_num2); end
    vec++; if (n_num1 !== 32'd0 || n_num2 !== 32'd0) begin errs++; $display("FAIL fwd_off: got num1=%h num2=%h expected 0 0", n_num1, n_num2); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (id_ready !== 1'b0 || wb_data !== 32'd5 || wb_valid !== 1'b1) begin
        errs++; $display("FAIL stall_%0d: got ready=%0b v=%0b data=%h expected 0 1 5", i, id_ready, wb_valid, wb_data);
      end
      cyc();
    end
    wb_ready = 1'b1;
    #1;
    vec++; if (id_ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready: got %0b expected 1", id_ready); end
    sb_q.push_back({1'b1, 5'd2, 32'd10});
    cyc();
    id_valid = 1'b0;
    vec++; if (wb_valid !== 1'b1 || wb_data !== 32'd10 || wb_rd !== 5'd2) begin
      errs++; $display("FAIL back_to_back: got v=%0b rd=%0d data=%h expected 1 2 a", wb_valid, wb_rd, wb_data);
    end
    cyc();
    vec++; if (retire_cnt !== 32'd3) begin errs++; $display("FAIL b2b_retire_cnt: got %0d expected 3", retire_cnt); end
  endtask

  task automatic test_branch();
    wb_ready = 1'b1;
    set_instr(7'b1100011, 5'd3, 5'd4, 5'd5, 32'd1, 32'd1, 32'h20, 32'h1234, 1'b1, 32'h100);
    id_valid = 1'b1;
    sb_q.push_back({1'b0, 5'd5, 32'h1234});
    cyc();
    vec++; if ({redir_valid, redir_pc, flush} !== {1'b1, 32'h100, 1'b1}) begin
      errs++; $display("FAIL beq_redirect: got rv=%0b pc=%h flush=%0b expected 1 100 1", redir_valid, redir_pc, flush);
    end
    vec++; if (redirect_cnt !== 32'd1 || wb_we !== 1'b0) begin errs++; $display("FAIL beq_cnt_we: got cnt=%0d we=%0b expected 1 0", redirect_cnt, wb_we); end
    set_instr(7'b0010011, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h24, 32'h77, 1'b1, 32'h300);
    #1;
    vec++; if (id_ready !== 1'b1) begin errs++; $display("FAIL flush_ready: got %0b expected 1", id_ready); end
    cyc();
    vec++; if ({flush, redir_valid, wb_valid} !== 3'b100) begin
      errs++; $display("FAIL flush_cycle2: got flush=%0b rv=%0b wbv=%0b expected 1 0 0", flush, redir_valid, wb_valid);
    end
    cyc();
    vec++; if ({flush, wb_valid, redirect_cnt, redir_pc} !== {2'b00, 32'd1, 32'h100}) begin
      errs++; $display("FAIL flush_end: got flush=%0b wbv=%0b cnt=%0d pc=%h expected 0 0 1 100", flush, wb_valid, redirect_cnt, redir_pc);
    end
    set_instr(7'b0010011, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h100, 32'h99, 1'b0, 32'h0);
    sb_q.push_back({1'b1, 5'd4, 32'h99});
    cyc();
    id_valid = 1'b0;
    vec++; if (wb_valid !== 1'b1 || wb_data !== 32'h99) begin errs++; $display("FAIL post_flush_accept: got v=%0b data=%h expected 1 99", wb_valid, wb_data); end
    cyc();
  endtask

  task automatic test_jalr();
    wb_ready = 1'b1;
    set_instr(7'b1100111, 5'd2, 5'd0, 5'd1, 32'h200, 32'd0, 32'h40, 32'h44, 1'b1, 32'h203);
    id_valid = 1'b1;
    sb_q.push_back({1'b1, 5'd1, 32'h44});
    cyc();
    vec++; if ({redir_valid, redir_pc, redirect_cnt} !== {1'b1, 32'h202, 32'd2}) begin
      errs++; $display("FAIL jalr_redirect: got rv=%0b pc=%h cnt=%0d expected 1 202 2", redir_valid, redir_pc, redirect_cnt);
    end
    vec++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd1, 32'h44}) begin
      errs++; $display("FAIL jalr_wb: got we=%0b rd=%0d data=%h expected 1 1 44", wb_we, wb_rd, wb_data);
    end
    set_instr(7'b1100011, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h44, 32'h0, 1'b1, 32'h500);
    cyc();
    vec++; if (redir_valid !== 1'b0 || redir_pc !== 32'h202) begin errs++; $display("FAIL wrongpath_taken: got rv=%0b pc=%h expected 0 202", redir_valid, redir_pc); end
    cyc();
    id_valid = 1'b0;
    vec++; if (redirect_cnt !== 32'd2 || flush !== 1'b0) begin errs++; $display("FAIL wrongpath_cnt: got cnt=%0d flush=%0b expected 2 0", redirect_cnt, flush); end
  endtask

  task automatic test_reset_mid_flush();
    wb_ready = 1'b0;
    set_instr(7'b1101111, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h10, 32'h14, 1'b1, 32'h80);
    id_valid = 1'b1;
    cyc();
    id_valid = 1'b0;
    vec++; if (flush !== 1'b1 || wb_valid !== 1'b1) begin errs++; $display("FAIL pre_reset_state: got flush=%0b wbv=%0b expected 1 1", flush, wb_valid); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    vec++; if ({wb_valid, wb_we, wb_rd, wb_data} !== 39'd0) begin errs++; $display("FAIL midrst_wb: got %h expected 0", {wb_valid, wb_we, wb_rd, wb_data}); end
    vec++; if ({redir_valid, redir_pc, flush} !== 34'd0) begin errs++; $display("FAIL midrst_redirect: got %h expected 0", {redir_valid, redir_pc, flush}); end
    vec++; if ({retire_cnt, redirect_cnt} !== 64'd0) begin errs++; $display("FAIL midrst_counters: got %h expected 0", {retire_cnt, redirect_cnt}); end
    vec++; if (id_ready !== 1'b1) begin errs++; $display("FAIL midrst_id_ready: got %0b expected 1", id_ready); end
    wb_ready = 1'b1;
    set_instr(7'b0010011, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h0, 32'h3c, 1'b0, 32'h0);
    id_valid = 1'b1;
    sb_q.push_back({1'b1, 5'd7, 32'h3c});
    cyc();
    id_valid = 1'b0;
    vec++; if (wb_valid !== 1'b1 || wb_data !== 32'h3c) begin errs++; $display("FAIL postrst_accept: got v=%0b data=%h expected 1 3c", wb_valid, wb_data); end
    cyc();
    vec++; if (retire_cnt !== 32'd1) begin errs++; $display("FAIL postrst_retire: got %0d expected 1", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward_stall();
    test_branch();
    test_jalr();
    test_reset_mid_flush();
    cyc();
    vec++; if (sb_q.size() != 0) begin errs++; $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/riscv_ex_ctrl.md
Name: riscv_ex_ctrl

Overview:
- Execute-stage sequencer that owns the combinational ALU.
- Accepts decoded instructions from decode over a valid/ready handshake and drives the ALU operand and opcode fields, with forwarding from its own result register.
- Captures the ALU result into a single-entry EX/WB register with a valid/ready handshake to writeback.
- Turns a taken branch or jump into a registered fetch redirect plus a wrong-path flush window, and keeps retire and redirect counters.

Parameters:
FLUSH_CYCLES, 2, cycles in FLUSH state after a taken branch/jump (1..15)
FWD_EN, 1, 1 = forward EX/WB result to rs1/rs2 operands; 0 = no forwarding
CNT_W, 32, width of performance counters

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_id_valid  in  1  decode has an instruction
o_id_ready  out  1  block accepts (or discards) the instruction this cycle
i_opcode  in  7  opcode
i_funct7  in  7  funct7
i_funct3  in  3  funct3
i_rs1_idx  in  5  rs1 index
i_rs2_idx  in  5  rs2 index
i_rd_idx  in  5  rd index
i_rs1_val  in  32  register-file rs1 value
i_rs2_val  in  32  register-file rs2 value
i_imm  in  32  decoded immediate
i_pc  in  32  instruction PC
o_alu_opcode  out  7  to ALU
o_alu_funct7  out  7  to ALU
o_alu_funct3  out  3  to ALU
o_alu_num1  out  32  to ALU, forwarded rs1
o_alu_num2  out  32  to ALU, forwarded rs2
o_alu_imm  out  32  to ALU
o_alu_pc  out  32  to ALU
i_alu_if_branch  in  1  ALU taken-branch/jump flag
i_alu_num  in  32  ALU result
i_alu_pc  in  32  ALU target PC
o_wb_valid  out  1  EX/WB register holds a result
i_wb_ready  in  1  writeback consumes the result
o_wb_we  out  1  result must be written to the register file
o_wb_rd  out  5  destination index
o_wb_data  out  32  result
o_redirect_valid  out  1  one-cycle fetch redirect pulse
o_redirect_pc  out  32  redirect target
o_flush  out  1  upstream must kill its in-flight instructions
o_retire_cnt  out  CNT_W  results consumed by writeback
o_redirect_cnt  out  CNT_W  redirects issued

Behaviour:
- Reset: synchronous, i_rst_n sampled low at a rising edge.
  - State = RUN; flush counter = 0.
  - o_wb_valid, o_wb_we, o_wb_rd, o_wb_data = 0.
  - o_redirect_valid, o_redirect_pc, o_flush = 0.
  - Both counters = 0.
  - Reset mid-FLUSH or with o_wb_valid high abandons all state; the pending result is lost.
- ALU drive (combinational, every cycle):
  - o_alu_opcode/funct7/funct3/imm/pc = the corresponding inputs.
  - o_alu_num1 = o_wb_data if FWD_EN && o_wb_valid && o_wb_we && o_wb_rd == i_rs1_idx && i_rs1_idx != 0; else i_rs1_val.
  - o_alu_num2 uses the same rule with rs2.
- o_id_ready:
  - RUN: high when !o_wb_valid || i_wb_ready.
  - FLUSH: always high.
- Accept, RUN && i_id_valid && o_id_ready; next cycle:
  - o_wb_valid = 1, o_wb_rd = i_rd_idx, o_wb_data = i_alu_num.
  - o_wb_we = 0 if opcode is 1100011 (branch) or 0100011 (store), or rd == 0; else 1.
- Latency: accept to o_wb_valid is 1 cycle.
- Result held stable while o_wb_valid && !i_wb_ready.
- A wb handshake with no accept in the same cycle clears o_wb_valid next cycle.
- A wb handshake and an accept in the same cycle reload the register; o_wb_valid stays 1 (full throughput).
- Taken branch/jump (accept with i_alu_if_branch = 1):
  - The instruction still retires normally; JAL/JALR write pc+4.
  - Next cycle: state = FLUSH, o_redirect_valid = 1 for exactly that cycle, o_redirect_pc = {i_alu_pc[31:1], 1'b0} (captured), o_redirect_cnt += 1.
- FLUSH state:
  - o_flush = 1 for FLUSH_CYCLES consecutive cycles, then return to RUN.
  - Any i_id_valid in FLUSH is consumed and discarded: no EX/WB update, no redirect, even if the ALU reports taken.
  - A pending EX/WB result continues to drain normally during FLUSH.
- i_alu_if_branch is ignored when no accept occurs.
- Counters:
  - o_retire_cnt += 1 on each o_wb_valid && i_wb_ready.
  - Both counters wrap modulo 2^CNT_W.

Test Plan:
- ADDI x1, x0, 5 (imm = 5, ALU num = 5) accepted with i_wb_ready = 1 -> next cycle o_wb_valid = 1, o_wb_rd = 1, o_wb_data = 5, o_wb_we = 1; o_retire_cnt = 1 one cycle later.
- Back-to-back dependency: x1 = 5 held in EX/WB, then ADD x2, x1, x1 with i_rs1_val = i_rs2_val = 0 -> o_alu_num1 = o_alu_num2 = 5 in the accept cycle. Same case with FWD_EN = 0 -> 0 and 0.
- i_wb_ready = 0 for 3 cycles with o_wb_valid = 1 -> o_id_ready = 0; o_wb_data stable; second instruction held. i_wb_ready = 1 -> handshake and accept in the same cycle; o_wb_valid stays 1 with the new data.
- Taken BEQ with i_alu_pc = 0x100 -> next cycle o_redirect_valid = 1 pulse, o_redirect_pc = 0x100, o_flush = 1 for 2 cycles. Two wrong-path instructions are discarded with no wb; the third is accepted; o_redirect_cnt = 1, o_wb_we = 0 for the BEQ.
- JALR with i_alu_pc = 0x203, pc = 0x40, rd = 1 -> o_redirect_pc = 0x202; o_wb_data = i_alu_num (0x44) written to x1. A wrong-path instruction reporting taken during FLUSH -> no second redirect.
- i_rst_n = 0 for one cycle during FLUSH with o_wb_valid = 1 -> next cycle all outputs and counters 0, state RUN, o_id_ready = 1.
